// File: rtl/mavg_pkg.sv
// Shared types and helpers for the multi-channel moving-average filter.
// The stage-1 -> stage-2 payload fields are sized for the widest supported
// configuration (up to 256 channels, 32-bit samples, LOG2_DEPTH up to 15);
// the filter zero-extends into them and reads back only its own widths.
package mavg_pkg;

  localparam int PL_CHW = 8;
  localparam int PL_DW  = 32;
  localparam int PL_WSW = 4;

  typedef struct packed {
    logic              valid;
    logic [PL_CHW-1:0] ch;
    logic [PL_DW-1:0]  smp;      // newly accepted sample
    logic              rd_pend;  // RAM holds the word leaving the window
    logic [PL_WSW-1:0] win;      // log2 window the sample belongs to
  } s1_pl_t;

  // Running sum never overflows: at most 2^l2d samples of 2^dw-1 each.
  function automatic int sum_width(input int dw, input int l2d);
    return dw + l2d;
  endfunction

  // Window selects above the supported maximum fall back to the maximum.
  function automatic int clamp_win(input int sel, input int l2d);
    return (sel > l2d) ? l2d : sel;
  endfunction

endpackage

// File: rtl/mavg_ram.sv
// Simple dual-port history RAM: one write and one registered read per
// cycle. Read-first: a read of the address being written returns the old word.
module mavg_ram #(
  parameter int DW = 8,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  // Array and read register share one edge so the read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mavg_mc.sv
// Multi-channel time-multiplexed boxcar averager, window 2^win_sel.
// Stage 1 writes the sample to the shared history RAM and reads the word
// leaving the window; stage 2 updates the per-channel sum/fill flops and
// registers the mean. Define MAVG_ROUND_EN for round-half-up division,
// otherwise the mean is truncated.
module mavg_mc
  import mavg_pkg::*;
#(
  parameter int DW         = 8,
  parameter int LOG2_DEPTH = 7,
  parameter int NCH        = 4,
  localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int WSW       = $clog2(LOG2_DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [CHW-1:0] in_ch,
  input  logic [DW-1:0]  in_data,
  input  logic [WSW-1:0] win_sel,
  output logic           out_valid,
  output logic [CHW-1:0] out_ch,
  output logic [DW-1:0]  out_data,
  output logic           out_full
);

  localparam int SW = sum_width(DW, LOG2_DEPTH);
  localparam int FW = LOG2_DEPTH + 1;
  localparam int AW = CHW + LOG2_DEPTH;

  logic [NCH-1:0][LOG2_DEPTH-1:0] ptr_q, ptr_d;
  logic [NCH-1:0][SW-1:0]         sum_q, sum_d;
  logic [NCH-1:0][FW-1:0]         fill_q, fill_d;
  logic [WSW-1:0]                 win_q, win_d;
  s1_pl_t                         s1_q, s1_d;
  logic                           out_valid_q, out_valid_d;
  logic [CHW-1:0]                 out_ch_q, out_ch_d;
  logic [DW-1:0]                  out_data_q, out_data_d;
  logic                           out_full_q, out_full_d;

  logic [WSW-1:0]        win_new;
  logic                  win_chg, acc;
  logic [LOG2_DEPTH-1:0] ptr_cur;
  logic [AW-1:0]         wr_addr, rd_addr;
  logic [DW-1:0]         rd_data;

  logic [WSW-1:0] win2;
  logic [CHW-1:0] ch2;
  logic [FW-1:0]  w_full, cur_fill, new_fill;
  logic [SW-1:0]  cur_sum, new_sum, rnd;
  logic           at_full;

  // Stage 1: accept, address the RAM, advance the channel pointer, build payload.
  always_comb begin
    win_new = WSW'(clamp_win(int'(win_sel), LOG2_DEPTH));
    win_chg = (win_new != win_q);
    win_d   = win_new;
    acc     = !rst && in_valid && (32'(in_ch) < NCH);
    ptr_cur = ptr_q[in_ch];
    wr_addr = {in_ch, ptr_cur};
    // At the maximum window the shift wraps to 0, so the read hits the write address.
    rd_addr = {in_ch, ptr_cur - (LOG2_DEPTH'(1) << win_new)};
    ptr_d   = ptr_q;
    if (acc) ptr_d[in_ch] = ptr_cur + LOG2_DEPTH'(1);
    s1_d         = '0;
    s1_d.valid   = acc;
    s1_d.ch      = PL_CHW'(in_ch);
    s1_d.smp     = PL_DW'(in_data);
    s1_d.rd_pend = acc;
    s1_d.win     = PL_WSW'(win_new);
  end

  mavg_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (acc),
    .waddr (wr_addr),
    .wdata (in_data),
    .re    (acc),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Stage 2: fold the new sample into the channel sum, evict the old word once
  // the window is full, and register the mean; a window change wipes sum/fill.
  always_comb begin
    sum_d    = sum_q;
    fill_d   = fill_q;
    win2     = s1_q.win[WSW-1:0];
    ch2      = s1_q.ch[CHW-1:0];
    w_full   = FW'(1) << win2;
    cur_sum  = sum_q[ch2];
    cur_fill = fill_q[ch2];
    at_full  = (cur_fill == w_full);
    new_sum  = cur_sum + SW'(s1_q.smp[DW-1:0])
             - ((at_full && s1_q.rd_pend) ? SW'(rd_data) : '0);
    new_fill = at_full ? cur_fill : cur_fill + FW'(1);
`ifdef MAVG_ROUND_EN
    rnd = (win2 != '0) ? (SW'(1) << (win2 - WSW'(1))) : '0;
`else
    rnd = '0;
`endif
    out_valid_d = s1_q.valid;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_full_d  = out_full_q;
    if (s1_q.valid) begin
      sum_d[ch2]  = new_sum;
      fill_d[ch2] = new_fill;
      out_ch_d    = ch2;
      out_data_d  = DW'((new_sum + rnd) >> win2);
      out_full_d  = (new_fill == w_full);
    end
    // The in-flight result above still goes out; only its write-back is dropped.
    if (win_chg) begin
      sum_d  = '0;
      fill_d = '0;
    end
  end

  // State registers; reset drops in-flight samples and adopts the current window.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      sum_q       <= '0;
      fill_q      <= '0;
      win_q       <= win_new;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_full_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      sum_q       <= sum_d;
      fill_q      <= fill_d;
      win_q       <= win_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_full_q  <= out_full_d;
    end
  end

  // Payload bits above this configuration's widths are always zero.
  logic unused_pl;
  assign unused_pl = ^s1_q;

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_full  = out_full_q;

endmodule

// File: tb/tb_mavg_mc.sv
// Scoreboard bench for mavg_mc: a per-channel sample-history model predicts
// each result at issue time; a negedge monitor pops and compares.
module tb_mavg_mc;

  localparam int DW = 8, L = 7, NCH = 4, CHW = 2, WSW = 3;

  logic           clk = 1'b0;
  logic           rst, in_valid, out_valid, out_full;
  logic [CHW-1:0] in_ch, out_ch;
  logic [DW-1:0]  in_data, out_data;
  logic [WSW-1:0] win_sel;

  // second instance with a non-power-of-two channel count for the invalid-channel case
  logic       v3, ov3, of3;
  logic [1:0] ch3, oc3;
  logic [7:0] d3, od3;
  logic [2:0] win3;

  always #5 clk = ~clk;

  mavg_mc #(.DW(DW), .LOG2_DEPTH(L), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .win_sel(win_sel), .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data),
    .out_full(out_full)
  );

  mavg_mc #(.DW(8), .LOG2_DEPTH(7), .NCH(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ch(ch3), .in_data(d3),
    .win_sel(win3), .out_valid(ov3), .out_ch(oc3), .out_data(od3), .out_full(of3)
  );

  typedef struct { int due; int ch; int data; int full; } exp_t;
  exp_t sbq[$];
  int   hist[NCH][$];
  int   mwin;
  int   checks = 0, failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int clampw(input int s);
    return (s > L) ? L : s;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Mean of the last min(n, W) samples since the channel's last clear.
  task automatic model_sample(input int ch, input int d);
    int w, n, s, rnd;
    hist[ch].push_back(d);
    w = 1 << mwin;
    n = hist[ch].size();
    s = 0;
    for (int i = (n > w) ? n - w : 0; i < n; i++) s += hist[ch][i];
`ifdef MAVG_ROUND_EN
    rnd = (mwin > 0) ? (1 << (mwin - 1)) : 0;
`else
    rnd = 0;
`endif
    sbq.push_back('{cyc + 2, ch, (s + rnd) >> mwin, (n >= w) ? 1 : 0});
    if (hist[ch].size() > (1 << L)) void'(hist[ch].pop_front());
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) hist[c].delete();
  endtask

  // One cycle of stimulus on the main DUT, mirrored into the model.
  task automatic drive(input bit r, input bit v, input int ch, input int d, input int ws);
    @(posedge clk); #1;
    rst = r; in_valid = v; in_ch = CHW'(ch); in_data = DW'(d); win_sel = WSW'(ws);
    if (r) begin
      // results not yet on the output are lost
      while (sbq.size() > 0 && sbq[$].due > cyc) void'(sbq.pop_back());
      model_clear();
      mwin = clampw(ws);
    end else begin
      if (clampw(ws) != mwin) begin
        model_clear();
        mwin = clampw(ws);
      end
      if (v && ch < NCH) model_sample(ch, d);
    end
  endtask

  task automatic idle(input int n, input int ws);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, ws);
  endtask

  // Monitor: every strobe must match the oldest expectation, on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0 && sbq[0].due < cyc) begin
      checks++; failures++;
      $display("FAIL missing_result due=%0d now=%0d ch=%0d", sbq[0].due, cyc, sbq[0].ch);
      void'(sbq.pop_front());
    end
    if (out_valid !== 1'b0) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid cyc=%0d ch=%0d data=%0d", cyc, out_ch, out_data);
      end else begin
        e = sbq.pop_front();
        if (out_valid !== 1'b1 || e.due != cyc || int'(out_ch) != e.ch ||
            int'(out_data) != e.data || int'(out_full) != e.full) begin
          failures++;
          $display("FAIL result cyc=%0d got ch=%0d data=%0d full=%0d exp due=%0d ch=%0d data=%0d full=%0d",
                   cyc, out_ch, out_data, out_full, e.due, e.ch, e.data, e.full);
        end
      end
    end
  end

  initial begin
    int ws, cnt;
    rst = 1; in_valid = 1; in_ch = 0; in_data = 8'hAA; win_sel = 3'd2; mwin = 2;
    v3 = 0; ch3 = 0; d3 = 0; win3 = 3'd2;

    // reset held 3 cycles with in_valid high: outputs stay cleared
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 8'hAA, 2);
      @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_full", int'(out_full), 0);
    end
    drive(0, 1, 0, 200, 2);
    @(negedge clk);
    chk("post_rst_out_valid", int'(out_valid), 0);
    chk("post_rst_out_data", int'(out_data), 0);
    chk("post_rst_out_ch", int'(out_ch), 0);
    idle(3, 2);

    // fill-up at W=4 on channel 0
    drive(1, 0, 0, 0, 2);
    for (int i = 1; i <= 5; i++) drive(0, 1, 0, i, 2);
    idle(3, 2);

    // maximum window, constant full-scale input
    drive(1, 0, 0, 0, 7);
    for (int i = 0; i < 130; i++) drive(0, 1, 0, 255, 7);
    idle(3, 7);

    // round-robin interleave across all channels
    drive(1, 0, 0, 0, 2);
    for (int i = 0; i < 16; i++) drive(0, 1, i % 4, 10 * (i % 4 + 1), 2);
    idle(3, 2);

    // window change while full: in-flight keeps W=4, then restart at W=2
    drive(1, 0, 0, 0, 2);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 100, 2);
    drive(0, 1, 0, 100, 1);
    drive(0, 1, 0, 100, 1);
    idle(3, 1);

    // reset with samples in flight, then channel 1 restarts empty
    drive(1, 0, 0, 0, 2);
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 60, 2);
    drive(0, 1, 1, 77, 2);
    drive(1, 1, 1, 88, 2);
    drive(1, 0, 1, 0, 2);
    drive(0, 1, 1, 40, 2);
    idle(3, 2);

    // randomized traffic with occasional window changes and resets
    ws = 2;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 39) == 0) ws = $urandom_range(0, 7);
      if ($urandom_range(0, 199) == 0) drive(1, 1, 0, 0, ws);
      else drive(0, ($urandom_range(0, 99) < 85), $urandom_range(0, NCH - 1),
                 $urandom_range(0, 255), ws);
    end
    idle(4, ws);

    // out-of-range channel on a 3-channel instance is dropped
    @(posedge clk); #1; v3 = 1; ch3 = 2'd3; d3 = 8'd200;
    @(posedge clk); #1; v3 = 0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ov3 !== 1'b0) cnt++;
    end
    chk("invalid_ch_no_valid", cnt, 0);
    @(posedge clk); #1; v3 = 1; ch3 = 2'd2; d3 = 8'd200;
    @(posedge clk); #1; v3 = 0;
    @(negedge clk);
    chk("ch3_latency_not_early", int'(ov3), 0);
    @(negedge clk);
    chk("ch3_valid", int'(ov3), 1);
    chk("ch3_ch", int'(oc3), 2);
    chk("ch3_data", int'(od3), 50);
    chk("ch3_full", int'(of3), 0);

    idle(3, ws);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
